// File: rtl/frame_addr_sweeper_if.sv
// Issue/acknowledge link between the frame-address sweeper and the write_reg block.
// Handshake: the sweeper strobes en for one cycle with frameaddr valid; write_reg answers with a one-cycle flag.
interface frame_addr_sweeper_if;
  logic        en;
  logic        flag;
  logic [31:0] frameaddr;

  modport master (output en, output frameaddr, input flag);
  modport slave  (input en, input frameaddr, output flag);
endinterface

// File: rtl/frame_addr_sweeper.sv
// Key-started sweep over a rectangle of configuration frames (minor fastest, then column, then row),
// issuing one write_reg request per frame with step mode, abort, flag timeout and frame counting.
module frame_addr_sweeper #(
  parameter logic [2:0] BLK_TYPE = 3'd0,
  parameter logic       TOP      = 1'b1,
  parameter int         ROW_LO   = 0,
  parameter int         ROW_HI   = 31,
  parameter int         COL_LO   = 0,
  parameter int         COL_HI   = 1023,
  parameter int         MINOR_LO = 0,
  parameter int         MINOR_HI = 127,
  parameter int         TIMEOUT  = 1023,
  parameter int         TO_W     = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 step_mode,
  input  logic                 step,
  frame_addr_sweeper_if.master wr,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout_err,
  output logic [23:0]          frame_cnt,
  output logic [1:0]           state_dbg
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_HOLD = 2'd2} state_t;

  localparam logic [4:0]      R_LO    = 5'(ROW_LO);
  localparam logic [4:0]      R_HI    = 5'(ROW_HI);
  localparam logic [9:0]      C_LO    = 10'(COL_LO);
  localparam logic [9:0]      C_HI    = 10'(COL_HI);
  localparam logic [6:0]      M_LO    = 7'(MINOR_LO);
  localparam logic [6:0]      M_HI    = 7'(MINOR_HI);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_t          state_q, state_d;
  logic [4:0]      row_q, row_d;
  logic [9:0]      col_q, col_d;
  logic [6:0]      minor_q, minor_d;
  logic            en_q, en_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            terr_q, terr_d;
  logic [23:0]     cnt_q, cnt_d;
  logic [TO_W-1:0] to_q, to_d;
  logic            is_last;

  assign is_last = (row_q == R_HI) && (col_q == C_HI) && (minor_q == M_HI);

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    minor_d = minor_q;
    en_d    = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    terr_d  = terr_q;
    cnt_d   = cnt_q;
    to_d    = to_q;
    case (state_q)
      S_IDLE: begin
        // abort wins over start; a stray flag here is deliberately ignored
        if (start && !abort) begin
          row_d   = R_LO;
          col_d   = C_LO;
          minor_d = M_LO;
          cnt_d   = 24'd0;
          terr_d  = 1'b0;
          en_d    = 1'b1;
          busy_d  = 1'b1;
          to_d    = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (abort) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else if (flag_in()) begin
          cnt_d = cnt_q + 24'd1;
          if (is_last) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            if (minor_q == M_HI) begin
              minor_d = M_LO;
              if (col_q == C_HI) begin
                col_d = C_LO;
                row_d = row_q + 5'd1;
              end else begin
                col_d = col_q + 10'd1;
              end
            end else begin
              minor_d = minor_q + 7'd1;
            end
            if (step_mode) begin
              state_d = S_HOLD;
            end else begin
              en_d = 1'b1;
              to_d = '0;
            end
          end
        end else if ((TIMEOUT != 0) && (to_q == TO_LAST)) begin
          terr_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      S_HOLD: begin
        // address was already advanced when the flag arrived
        if (abort) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else if (step) begin
          en_d    = 1'b1;
          to_d    = '0;
          state_d = S_WAIT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  function automatic logic flag_in();
    return wr.flag;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      row_q   <= R_LO;
      col_q   <= C_LO;
      minor_q <= M_LO;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      terr_q  <= 1'b0;
      cnt_q   <= 24'd0;
      to_q    <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      minor_q <= minor_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      terr_q  <= terr_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
    end
  end

  assign wr.en        = en_q;
  assign wr.frameaddr = {6'b0, BLK_TYPE, TOP, row_q, col_q, minor_q};
  assign busy         = busy_q;
  assign done         = done_q;
  assign timeout_err  = terr_q;
  assign frame_cnt    = cnt_q;
  assign state_dbg    = state_q;

endmodule
